// File: rtl/hazard_forward_unit_if.sv
// Decode-side hazard inputs and execute-side forward/stall/flush controls.
// The slave modport is the hazard unit's view; master is the pipeline's.
interface hazard_forward_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  valid_d;
  logic [REG_ADDR_W-1:0] rs1_d;
  logic [REG_ADDR_W-1:0] rs2_d;
  logic [REG_ADDR_W-1:0] rd_d;
  logic                  reg_write_d;
  logic                  load_d;
  logic                  pc_src_e;
  logic [1:0]            forward_a_e;
  logic [1:0]            forward_b_e;
  logic                  stall_f;
  logic                  stall_d;
  logic                  flush_d;
  logic                  flush_e;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_cycles;

  modport master (
    output valid_d, rs1_d, rs2_d, rd_d,
    output reg_write_d, load_d, pc_src_e,
    input  forward_a_e, forward_b_e,
    input  stall_f, stall_d, flush_d, flush_e,
    input  stall_cycles, flush_cycles
  );

  modport slave (
    input  valid_d, rs1_d, rs2_d, rd_d,
    input  reg_write_d, load_d, pc_src_e,
    output forward_a_e, forward_b_e,
    output stall_f, stall_d, flush_d, flush_e,
    output stall_cycles, flush_cycles
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the 5-stage pipeline.
// Optional perf counters enabled by HAZARD_PERF_CNT_EN.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input logic             clk,
  input logic             rst,
  hazard_forward_unit_if.slave hz
);

  typedef logic [REG_ADDR_W-1:0] reg_t;

  typedef struct packed {
    reg_t rs1;
    reg_t rs2;
    reg_t rd;
    logic reg_write;
    logic load;
  } e_t;

  typedef struct packed {
    reg_t rd;
    logic reg_write;
  } mw_t;

  e_t   e_q;
  e_t   e_nxt;
  mw_t  m_q;
  mw_t  w_q;

  logic lw_stall;
  logic flush_e_raw;
  logic a_m, a_w, a_w_only;
  logic b_m, b_w, b_w_only;
  logic [1:0] fa;
  logic [1:0] fb;

  assign lw_stall = hz.valid_d && e_q.load
                 && (e_q.rd != '0)
                 && ((e_q.rd == hz.rs1_d)
                  || (e_q.rd == hz.rs2_d));

  assign flush_e_raw = lw_stall || hz.pc_src_e;

  always_comb begin
    e_nxt = '0;
    if (hz.valid_d && !flush_e_raw) begin
      e_nxt.rs1       = hz.rs1_d;
      e_nxt.rs2       = hz.rs2_d;
      e_nxt.rd        = hz.rd_d;
      e_nxt.reg_write = hz.reg_write_d;
      e_nxt.load      = hz.load_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_nxt;
      m_q <= '{rd: e_q.rd, reg_write: e_q.reg_write};
      w_q <= m_q;
    end
  end

  assign a_m = m_q.reg_write && (m_q.rd != '0)
            && (m_q.rd == e_q.rs1);
  assign a_w = w_q.reg_write && (w_q.rd != '0)
            && (w_q.rd == e_q.rs1);
  assign b_m = m_q.reg_write && (m_q.rd != '0)
            && (m_q.rd == e_q.rs2);
  assign b_w = w_q.reg_write && (w_q.rd != '0)
            && (w_q.rd == e_q.rs2);

  // The younger result in M shadows the older one in W.
  assign a_w_only = a_w && !a_m;
  assign b_w_only = b_w && !b_m;

  always_comb begin
    fa = 2'b00;
    unique case (1'b1)
      a_m:      fa = 2'b10;
      a_w_only: fa = 2'b01;
      default:  fa = 2'b00;
    endcase
  end

  always_comb begin
    fb = 2'b00;
    unique case (1'b1)
      b_m:      fb = 2'b10;
      b_w_only: fb = 2'b01;
      default:  fb = 2'b00;
    endcase
  end

  assign hz.forward_a_e = rst ? fa : 2'b00;
  assign hz.forward_b_e = rst ? fb : 2'b00;
  assign hz.stall_f = rst && lw_stall && !hz.pc_src_e;
  assign hz.stall_d = rst && lw_stall && !hz.pc_src_e;
  assign hz.flush_d = rst && hz.pc_src_e;
  assign hz.flush_e = rst && flush_e_raw;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] sc_q;
  logic [CNT_W-1:0] fc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sc_q <= '0;
      fc_q <= '0;
    end else begin
      if (hz.stall_d && (sc_q != '1))
        sc_q <= sc_q + CNT_W'(1);
      if (hz.flush_e && (fc_q != '1))
        fc_q <= fc_q + CNT_W'(1);
    end
  end

  assign hz.stall_cycles = rst ? sc_q : '0;
  assign hz.flush_cycles = rst ? fc_q : '0;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
  assign hz.flush_cycles = {CNT_W{1'b0}};
`endif

endmodule
